// File: rtl/apb_uart_fifo.sv
// APB3 UART with TX/RX FIFOs, 16-bit baud divider, parity and 1/2 stop bits.
// Define UART_LOOPBACK_EN to implement CTRL[6] internal loopback.
module apb_uart_fifo_buf #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  // A pop frees the slot, so a full FIFO may push in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PTR_ONE;
    if (do_pop)  rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end
endmodule

module apb_uart_fifo #(
  parameter int          TX_DEPTH   = 16,
  parameter int          RX_DEPTH   = 16,
  parameter int          APB_DWIDTH = 16,
  parameter logic [15:0] RESET_DIV  = 16'd0
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic [4:0]            PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_DWIDTH-1:0] PWDATA,
  output logic [APB_DWIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic                  RX,
  output logic                  TX,
  output logic                  TXRDY,
  output logic                  RXRDY,
  output logic                  IRQ
);
`ifdef UART_LOOPBACK_EN
  localparam int CW = 7;
`else
  localparam int CW = 6;
`endif

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  logic [CW-1:0]         ctrl_q, ctrl_d;
  logic [2:0]            ien_q, ien_d;
  logic [15:0]           baud_q, baud_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  rovf_q, rovf_d;
  logic                  tovf_q, tovf_d;
  logic [APB_DWIDTH-1:0] prdata_q, prdata_d;

  tx_state_e             tst_q, tst_d;
  logic [3:0]            tcnt_q, tcnt_d;
  logic [2:0]            tbit_q, tbit_d;
  logic [7:0]            tdata_q, tdata_d;

  rx_state_e             rst_q, rst_d;
  logic [3:0]            rcnt_q, rcnt_d;
  logic [2:0]            rbit_q, rbit_d;
  logic [7:0]            rsh_q, rsh_d;
  logic                  rpar_q, rpar_d;
  logic                  rx1_q, rx2_q, rx3_q;

  logic [2:0]  addr;
  logic        setup_rd, acc_wr, acc_rd;
  logic        tick;
  logic        bit8, par_en, odd, two_stop, tx_en, rx_en, lb;
  logic [2:0]  last_bit;
  logic        tx_wr, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_rdata;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_rdata, rx_byte;
  logic        set_perr, set_ferr;
  logic        tx_line, tx_par, rx_in, tx_busy;
  logic [8:0]  status;
  logic [15:0] rd_val;
  logic        unused_ok;

  assign unused_ok = ^{PADDR[1:0], PWDATA};

  assign addr     = PADDR[4:2];
  assign setup_rd = PSEL & ~PENABLE & ~PWRITE;
  assign acc_wr   = PSEL & PENABLE & PWRITE;
  assign acc_rd   = PSEL & PENABLE & ~PWRITE;

  assign bit8     = ctrl_q[0];
  assign par_en   = ctrl_q[1];
  assign odd      = ctrl_q[2];
  assign two_stop = ctrl_q[3];
  assign tx_en    = ctrl_q[4];
  assign rx_en    = ctrl_q[5];
  assign last_bit = bit8 ? 3'd7 : 3'd6;

`ifdef UART_LOOPBACK_EN
  assign lb    = ctrl_q[6];
  assign rx_in = lb ? tx_line : RX;
`else
  assign lb    = 1'b0;
  assign rx_in = RX;
`endif

  assign tick   = (cnt_q == baud_q);
  assign tx_wr  = acc_wr & (addr == 3'd0);
  assign rx_pop = acc_rd & (addr == 3'd1) & ~rx_empty;

  apb_uart_fifo_buf #(.DEPTH(TX_DEPTH)) u_txf (
    .clk   (PCLK),
    .rst_n (PRESETN),
    .push  (tx_wr),
    .pop   (tx_pop),
    .wdata (PWDATA[7:0]),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty)
  );

  apb_uart_fifo_buf #(.DEPTH(RX_DEPTH)) u_rxf (
    .clk   (PCLK),
    .rst_n (PRESETN),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_byte),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Transmitter
  always_comb begin
    tst_d   = tst_q;
    tcnt_d  = tcnt_q;
    tbit_d  = tbit_q;
    tdata_d = tdata_q;
    tx_pop  = 1'b0;
    if (tick) begin
      if (tst_q == TX_IDLE) begin
        if (tx_en && !tx_empty) begin
          tst_d   = TX_START;
          tcnt_d  = 4'd0;
          tbit_d  = 3'd0;
          tdata_d = tx_rdata;
          tx_pop  = 1'b1;
        end
      end else if (tcnt_q != 4'd15) begin
        tcnt_d = tcnt_q + 4'd1;
      end else begin
        tcnt_d = 4'd0;
        unique case (tst_q)
          TX_START: tst_d = TX_DATA;
          TX_DATA: begin
            if (tbit_q == last_bit)
              tst_d = par_en ? TX_PARITY : TX_STOP1;
            else
              tbit_d = tbit_q + 3'd1;
          end
          TX_PARITY: tst_d = TX_STOP1;
          TX_STOP1:  tst_d = two_stop ? TX_STOP2 : TX_IDLE;
          default:   tst_d = TX_IDLE;
        endcase
      end
    end
  end

  assign tx_par  = ^(bit8 ? tdata_q : {1'b0, tdata_q[6:0]}) ^ odd;
  assign tx_busy = (tst_q != TX_IDLE);

  always_comb begin
    unique case (tst_q)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tdata_q[tbit_q];
      TX_PARITY: tx_line = tx_par;
      default:   tx_line = 1'b1;
    endcase
  end

  assign TX = lb | tx_line;

  // Receiver: bits sampled on the 8th tick after each bit boundary
  assign rx_byte = bit8 ? rsh_q : {1'b0, rsh_q[6:0]};

  always_comb begin
    rst_d    = rst_q;
    rcnt_d   = rcnt_q;
    rbit_d   = rbit_q;
    rsh_d    = rsh_q;
    rpar_d   = rpar_q;
    rx_push  = 1'b0;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    if (!rx_en) begin
      rst_d = RX_IDLE;
    end else if (rst_q == RX_IDLE) begin
      if (rx3_q && !rx2_q) begin
        rst_d  = RX_START;
        rcnt_d = 4'd0;
        rbit_d = 3'd0;
      end
    end else if (tick) begin
      rcnt_d = rcnt_q + 4'd1;
      unique case (rst_q)
        RX_START: begin
          if (rcnt_q == 4'd7 && rx2_q) rst_d = RX_IDLE;
          else if (rcnt_q == 4'd15)    rst_d = RX_DATA;
        end
        RX_DATA: begin
          if (rcnt_q == 4'd7) rsh_d[rbit_q] = rx2_q;
          if (rcnt_q == 4'd15) begin
            if (rbit_q == last_bit)
              rst_d = par_en ? RX_PARITY : RX_STOP;
            else
              rbit_d = rbit_q + 3'd1;
          end
        end
        RX_PARITY: begin
          if (rcnt_q == 4'd7)  rpar_d = rx2_q;
          if (rcnt_q == 4'd15) rst_d = RX_STOP;
        end
        RX_STOP: begin
          if (rcnt_q == 4'd7) begin
            rx_push  = 1'b1;
            set_ferr = ~rx2_q;
            set_perr = par_en & (rpar_q != (^rx_byte ^ odd));
            rst_d    = RX_IDLE;
          end
        end
        default: rst_d = RX_IDLE;
      endcase
    end
  end

  assign status = {tovf_q, rovf_q, ferr_q, perr_q,
                   tx_busy, rx_full, tx_empty, ~rx_empty, ~tx_full};

  // Register file; sticky flags favour a new event over a same-cycle clear
  always_comb begin
    ctrl_d = ctrl_q;
    ien_d  = ien_q;
    baud_d = baud_q;
    cnt_d  = tick ? 16'd0 : cnt_q + 16'd1;
    perr_d = perr_q;
    ferr_d = ferr_q;
    rovf_d = rovf_q;
    tovf_d = tovf_q;
    if (acc_wr) begin
      case (addr)
        3'd2: begin
          baud_d = PWDATA[15:0];
          cnt_d  = 16'd0;
        end
        3'd3: ctrl_d = PWDATA[CW-1:0];
        3'd4: begin
          perr_d = perr_q & ~PWDATA[5];
          ferr_d = ferr_q & ~PWDATA[6];
          rovf_d = rovf_q & ~PWDATA[7];
          tovf_d = tovf_q & ~PWDATA[8];
        end
        3'd5: ien_d = PWDATA[2:0];
        default: ;
      endcase
    end
    if (set_perr) perr_d = 1'b1;
    if (set_ferr) ferr_d = 1'b1;
    if (rx_push && rx_full && !rx_pop)  rovf_d = 1'b1;
    if (tx_wr && tx_full && !tx_pop)    tovf_d = 1'b1;
  end

  always_comb begin
    case (addr)
      3'd1:    rd_val = rx_empty ? 16'd0 : {8'd0, rx_rdata};
      3'd2:    rd_val = baud_q;
      3'd3:    rd_val = 16'(ctrl_q);
      3'd4:    rd_val = 16'(status);
      3'd5:    rd_val = {13'd0, ien_q};
      default: rd_val = 16'd0;
    endcase
    prdata_d = setup_rd ? APB_DWIDTH'(rd_val) : prdata_q;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      ctrl_q   <= '0;
      ien_q    <= '0;
      baud_q   <= RESET_DIV;
      cnt_q    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      rovf_q   <= 1'b0;
      tovf_q   <= 1'b0;
      prdata_q <= '0;
      tst_q    <= TX_IDLE;
      tcnt_q   <= '0;
      tbit_q   <= '0;
      tdata_q  <= '0;
      rst_q    <= RX_IDLE;
      rcnt_q   <= '0;
      rbit_q   <= '0;
      rsh_q    <= '0;
      rpar_q   <= 1'b0;
      rx1_q    <= 1'b1;
      rx2_q    <= 1'b1;
      rx3_q    <= 1'b1;
    end else begin
      ctrl_q   <= ctrl_d;
      ien_q    <= ien_d;
      baud_q   <= baud_d;
      cnt_q    <= cnt_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      rovf_q   <= rovf_d;
      tovf_q   <= tovf_d;
      prdata_q <= prdata_d;
      tst_q    <= tst_d;
      tcnt_q   <= tcnt_d;
      tbit_q   <= tbit_d;
      tdata_q  <= tdata_d;
      rst_q    <= rst_d;
      rcnt_q   <= rcnt_d;
      rbit_q   <= rbit_d;
      rsh_q    <= rsh_d;
      rpar_q   <= rpar_d;
      rx1_q    <= rx_in;
      rx2_q    <= rx1_q;
      rx3_q    <= rx2_q;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign TXRDY   = ~tx_full;
  assign RXRDY   = ~rx_empty;
  assign IRQ     = (ien_q[0] & ~rx_empty) | (ien_q[1] & tx_empty) |
                   (ien_q[2] & (perr_q | ferr_q | rovf_q | tovf_q));
endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed bench for apb_uart_fifo: registers, TX/RX framing, FIFO limits.
module tb_apb_uart_fifo;
  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic [4:0]  PADDR = '0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [15:0] PWDATA = '0;
  logic [15:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        RX = 1'b1;
  logic        TX, TXRDY, RXRDY, IRQ;

  int checks = 0;
  int errors = 0;

  apb_uart_fifo dut (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .RX      (RX),
    .TX      (TX),
    .TXRDY   (TXRDY),
    .RXRDY   (RXRDY),
    .IRQ     (IRQ)
  );

  always #5 PCLK = ~PCLK;

  task automatic apb_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge PCLK);
    PADDR = {a, 2'b00}; PWDATA = d; PWRITE = 1'b1;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge PCLK);
    PADDR = {a, 2'b00}; PWRITE = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    d = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic pen,
                         input logic pbit, input int bc);
    RX = 1'b0;
    repeat (bc) @(negedge PCLK);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (bc) @(negedge PCLK);
    end
    if (pen) begin
      RX = pbit;
      repeat (bc) @(negedge PCLK);
    end
    RX = 1'b1;
    repeat (bc) @(negedge PCLK);
  endtask

  task automatic test_reset;
    logic [15:0] r;
    PRESETN = 1'b0;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({TX, TXRDY, RXRDY, IRQ} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_pins got %b want 1100", {TX, TXRDY, RXRDY, IRQ});
    end
    checks++;
    if (PRDATA !== 16'h0) begin
      errors++;
      $display("FAIL reset_prdata got %h want 0000", PRDATA);
    end
    PRESETN = 1'b1;
    apb_read(3'd3, r); checks++;
    if (r !== 16'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0000", r); end
    apb_read(3'd2, r); checks++;
    if (r !== 16'h0) begin errors++; $display("FAIL reset_baud got %h want 0000", r); end
    apb_read(3'd4, r); checks++;
    if (r !== 16'h0005) begin errors++; $display("FAIL reset_status got %h want 0005", r); end
    apb_read(3'd5, r); checks++;
    if (r !== 16'h0) begin errors++; $display("FAIL reset_ien got %h want 0000", r); end
    apb_read(3'd1, r); checks++;
    if (r !== 16'h0) begin errors++; $display("FAIL empty_rxdata got %h want 0000", r); end
    apb_write(3'd6, 16'hFFFF);
    apb_read(3'd6, r); checks++;
    if (r !== 16'h0) begin errors++; $display("FAIL addr6 got %h want 0000", r); end
    apb_write(3'd3, 16'h00FF);
    apb_read(3'd3, r); checks++;
`ifdef UART_LOOPBACK_EN
    if (r !== 16'h007F) begin errors++; $display("FAIL ctrl_mask got %h want 007f", r); end
`else
    if (r !== 16'h003F) begin errors++; $display("FAIL ctrl_mask got %h want 003f", r); end
`endif
    apb_write(3'd3, 16'h0000);
    apb_write(3'd5, 16'h0002);
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_txempty got %b want 1", IRQ); end
    apb_write(3'd5, 16'h0000);
  endtask

  task automatic test_tx_frame;
    logic [15:0] r;
    logic [7:0]  exp_b;
    int          w;
    exp_b = 8'hA5;
    apb_write(3'd2, 16'd3);
    apb_write(3'd3, 16'h0011);
    apb_write(3'd0, 16'h00A5);
    w = 0;
    while (TX === 1'b1 && w < 200) begin @(negedge PCLK); w++; end
    checks++;
    if (TX !== 1'b0) begin
      errors++; $display("FAIL tx_start_timeout got %b want 0", TX);
      return;
    end
    repeat (32) @(negedge PCLK);
    checks++;
    if (TX !== 1'b0) begin errors++; $display("FAIL tx_startbit got %b want 0", TX); end
    for (int i = 0; i < 8; i++) begin
      repeat (64) @(negedge PCLK);
      checks++;
      if (TX !== exp_b[i]) begin
        errors++; $display("FAIL tx_bit%0d got %b want %b", i, TX, exp_b[i]);
      end
    end
    repeat (64) @(negedge PCLK);
    checks++;
    if (TX !== 1'b1) begin errors++; $display("FAIL tx_stopbit got %b want 1", TX); end
    apb_read(3'd4, r); checks++;
    if (r !== 16'h0015) begin errors++; $display("FAIL tx_busy_mid got %h want 0015", r); end
    repeat (40) @(negedge PCLK);
    apb_read(3'd4, r); checks++;
    if (r !== 16'h0005) begin errors++; $display("FAIL tx_busy_done got %h want 0005", r); end
  endtask

  task automatic test_rx_parity;
    logic [15:0] r;
    apb_write(3'd2, 16'd1);
    apb_write(3'd3, 16'h0037);
    send_rx(8'h3C, 1'b1, 1'b0, 32);
    checks++;
    if (RXRDY !== 1'b1) begin errors++; $display("FAIL rx_rdy got %b want 1", RXRDY); end
    apb_read(3'd4, r); checks++;
    if (r !== 16'h0027) begin errors++; $display("FAIL rx_perr_status got %h want 0027", r); end
    apb_write(3'd5, 16'h0004);
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_err got %b want 1", IRQ); end
    apb_read(3'd1, r); checks++;
    if (r !== 16'h003C) begin errors++; $display("FAIL rx_data got %h want 003c", r); end
    apb_write(3'd4, 16'h0020);
    apb_read(3'd4, r); checks++;
    if (r !== 16'h0005) begin errors++; $display("FAIL perr_clear got %h want 0005", r); end
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", IRQ); end
    apb_write(3'd5, 16'h0000);
  endtask

  task automatic test_rx_overflow;
    logic [15:0] r;
    apb_write(3'd3, 16'h0021);
    for (int i = 0; i < 17; i++) send_rx(8'h10 + 8'(i), 1'b0, 1'b0, 32);
    apb_read(3'd4, r); checks++;
    if (r !== 16'h008F) begin errors++; $display("FAIL rx_ovf_status got %h want 008f", r); end
    for (int i = 0; i < 16; i++) begin
      apb_read(3'd1, r); checks++;
      if (r !== 16'h0010 + 16'(i)) begin
        errors++; $display("FAIL rx_order%0d got %h want %h", i, r, 16'h0010 + 16'(i));
      end
    end
    apb_read(3'd4, r); checks++;
    if (r !== 16'h0085) begin errors++; $display("FAIL rx_drained got %h want 0085", r); end
    apb_write(3'd4, 16'h0080);
    apb_read(3'd4, r); checks++;
    if (r !== 16'h0005) begin errors++; $display("FAIL rx_ovf_clear got %h want 0005", r); end
  endtask

  task automatic test_tx_overflow;
    logic [15:0] r;
    logic [7:0]  got;
    int          n, w;
    apb_write(3'd2, 16'd0);
    apb_write(3'd3, 16'h0001);
    for (int i = 0; i < 17; i++) begin
      apb_write(3'd0, 16'h0040 + 16'(i));
      if (i == 14) begin
        checks++;
        if (TXRDY !== 1'b1) begin errors++; $display("FAIL txrdy_15 got %b want 1", TXRDY); end
      end
      if (i == 15) begin
        checks++;
        if (TXRDY !== 1'b0) begin errors++; $display("FAIL txrdy_16 got %b want 0", TXRDY); end
      end
    end
    apb_read(3'd4, r); checks++;
    if (r !== 16'h0100) begin errors++; $display("FAIL tx_ovf_status got %h want 0100", r); end
    apb_write(3'd4, 16'h0100);
    apb_read(3'd4, r); checks++;
    if (r !== 16'h0000) begin errors++; $display("FAIL tx_ovf_clear got %h want 0000", r); end
    apb_write(3'd3, 16'h0011);
    n = 0;
    forever begin
      w = 0;
      while (TX === 1'b1 && w < 40) begin @(negedge PCLK); w++; end
      if (TX !== 1'b0) break;
      repeat (8) @(negedge PCLK);
      for (int b = 0; b < 8; b++) begin
        repeat (16) @(negedge PCLK);
        got[b] = TX;
      end
      checks++;
      if (got !== 8'h40 + 8'(n)) begin
        errors++; $display("FAIL tx_frame%0d got %h want %h", n, got, 8'h40 + 8'(n));
      end
      repeat (16) @(negedge PCLK);
      n++;
      if (n > 20) break;
    end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL tx_frame_count got %0d want 16", n); end
    apb_read(3'd4, r); checks++;
    if (r !== 16'h0005) begin errors++; $display("FAIL tx_drained got %h want 0005", r); end
  endtask

`ifdef UART_LOOPBACK_EN
  task automatic test_loopback;
    logic [15:0] r;
    logic        txlow;
    int          w;
    apb_write(3'd2, 16'd0);
    apb_write(3'd3, 16'h0071);
    apb_write(3'd5, 16'h0001);
    apb_write(3'd0, 16'h005A);
    txlow = 1'b0;
    w = 0;
    while (IRQ !== 1'b1 && w < 400) begin
      if (TX !== 1'b1) txlow = 1'b1;
      @(negedge PCLK); w++;
    end
    checks++;
    if (txlow !== 1'b0) begin errors++; $display("FAIL lb_tx_pin got %b want 0", txlow); end
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL lb_irq got %b want 1", IRQ); end
    apb_read(3'd1, r); checks++;
    if (r !== 16'h005A) begin errors++; $display("FAIL lb_data got %h want 005a", r); end
    apb_write(3'd5, 16'h0000);
    apb_write(3'd3, 16'h0000);
  endtask
`endif

  task automatic test_reset_midframe;
    int w;
    apb_write(3'd2, 16'd0);
    apb_write(3'd3, 16'h0011);
    apb_write(3'd0, 16'h0000);
    w = 0;
    while (TX === 1'b1 && w < 40) begin @(negedge PCLK); w++; end
    repeat (20) @(negedge PCLK);
    checks++;
    if (TX !== 1'b0) begin errors++; $display("FAIL midframe_low got %b want 0", TX); end
    PRESETN = 1'b0;
    @(negedge PCLK);
    checks++;
    if (TX !== 1'b1) begin errors++; $display("FAIL midframe_reset got %b want 1", TX); end
    PRESETN = 1'b1;
  endtask

  initial begin
    test_reset;
    test_tx_frame;
    test_rx_parity;
    test_rx_overflow;
    test_tx_overflow;
`ifdef UART_LOOPBACK_EN
    test_loopback;
`endif
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_uart_fifo.md
Name: apb_uart_fifo

Overview:
- Parametrised successor to the existing APB-wrapped UART.
- Programmable 16-bit baud divider, configurable TX/RX FIFO depth and 1 or 2 stop bits.
- Sticky error flags with write-1-to-clear, and a maskable interrupt output.
- Sits on the fabric APB3 bus as a slave in the same slot style as the current UART.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of 2, >=2
- RX_DEPTH, 16, RX FIFO entries; power of 2, >=2
- APB_DWIDTH, 16, PWDATA/PRDATA width; >=16, upper bits read 0
- RESET_DIV, 0, reset value of BAUDDIV register

Ports:
- PCLK  in  1  system clock; all logic on rising edge
- PRESETN  in  1  synchronous active-low reset
- PADDR  in  5  byte address; decode PADDR[4:2]
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1=write
- PWDATA  in  APB_DWIDTH  write data
- PRDATA  out  APB_DWIDTH  registered read data
- PREADY  out  1  tied 1
- PSLVERR  out  1  tied 0
- RX  in  1  serial in, asynchronous
- TX  out  1  serial out, idle high
- TXRDY  out  1  TX FIFO not full
- RXRDY  out  1  RX FIFO not empty
- IRQ  out  1  OR of enabled interrupt sources

Behaviour:
- Interface: one clock, PCLK. Reset PRESETN is synchronous, active-low. Reset is sampled only on a PCLK rising edge.
- Reset values:
  - TX=1, PRDATA=0, TXRDY=1, RXRDY=0, IRQ=0.
  - FIFOs empty. CTRL=0. IEN=0. BAUDDIV=RESET_DIV. Flags=0. FSMs in IDLE.
  - Reset mid-frame aborts the frame; TX is high after the next edge.
- Register map, selected by PADDR[4:2]:
  - 0 TXDATA (W): push PWDATA[7:0]; reads 0.
  - 1 RXDATA (R): head of RX FIFO; pop on access phase.
  - 2 BAUDDIV (R/W): [15:0].
  - 3 CTRL (R/W):
    - [0] bit8 (1=8 data bits, 0=7)
    - [1] parity_en
    - [2] odd_n_even
    - [3] two_stop
    - [4] tx_en
    - [5] rx_en
    - [6] loopback
  - 4 STATUS:
    - [0] TXRDY, [1] RXRDY, [2] tx_empty, [3] rx_full, [4] tx_busy (read-only)
    - [5] parity_err, [6] framing_err, [7] rx_ovf, [8] tx_ovf (sticky; write 1 clears)
  - 5 IEN (R/W):
    - [0] rxrdy, [1] tx_empty, [2] any error
  - 6-7: read 0, writes ignored.
- APB read timing:
  - PRDATA is loaded in the setup phase (PSEL & !PENABLE & !PWRITE), so it is valid in the access phase.
  - PRDATA otherwise holds its value.
  - Writes take effect on the access-phase edge (PSEL & PENABLE & PWRITE).
- Baud tick:
  - Counter runs 0..BAUDDIV; tick16 fires when count==BAUDDIV, then the counter wraps.
  - Oversample rate = PCLK/(BAUDDIV+1). One bit period = 16 ticks.
  - A write to BAUDDIV clears the counter.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
  - Leaves IDLE on a tick16 when tx_en=1 and the FIFO is non-empty; pops the FIFO on that same cycle.
  - Data is sent LSB first, 7 or 8 bits.
  - Parity = XOR of data bits; odd_n_even=1 inverts it.
  - Clearing tx_en mid-frame: the current frame completes, then the FSM stays IDLE.
  - tx_busy = state != IDLE.
- RX path:
  - RX is double-flop synchronised.
  - RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - A falling edge in IDLE (rx_en=1) starts the tick count; the line is sampled at tick 8 of each bit.
  - If the start sample is 1, the frame is a false start: return to IDLE, nothing pushed.
  - STOP sample:
    - Push the byte (7-bit data zero-extended).
    - Stop sample 0 sets framing_err; the byte is still pushed.
    - Parity mismatch sets parity_err; the byte is still pushed.
    - FIFO full: byte dropped, rx_ovf set.
  - The receiver checks one stop bit regardless of two_stop.
  - Clearing rx_en returns the FSM to IDLE at once; the partial frame is discarded.
- FIFOs: pointers with an extra wrap bit.
  - Full with a simultaneous pop and push: both are performed and count is unchanged. No overflow for an RX push in the same cycle as an APB pop. A TXDATA write is accepted in the same cycle as a TX FSM pop.
  - TXDATA write when full with no pop: ignored, tx_ovf set.
  - RXDATA read when empty: returns 0, no pointer change.
- IRQ (combinational from registered state):
  - (IEN[0]&RXRDY) | (IEN[1]&tx_empty) | (IEN[2]&(parity_err|framing_err|rx_ovf|tx_ovf)).

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined:
  - CTRL[6]=1 routes internal TX to the RX synchroniser input; external RX is ignored.
  - The TX pin is held at 1 while loopback=1.
- Not defined:
  - CTRL[6] is not implemented; it reads 0 and writes are ignored.
  - No mux on the RX path.

Test Plan:
- Reset then read all registers -> CTRL=0, BAUDDIV=RESET_DIV, STATUS=0x0005, TX=1, IRQ=0.
- BAUDDIV=3, CTRL=0x11, write 0xA5 -> TX low for 64 PCLK, then bits 1,0,1,0,0,1,0,1 at 64 PCLK each, stop bit high; tx_busy=0 after 640 PCLK.
- CTRL=0x37 (8 bits, odd parity, rx_en), drive 0x3C with a wrong parity bit -> RXRDY=1, RXDATA=0x3C, STATUS[5]=1; write 0x20 to STATUS -> bit 5 clears.
- Receive RX_DEPTH+1 frames with no reads -> rx_full=1, rx_ovf=1, first RX_DEPTH bytes read back in order, last byte lost.
- Write TX_DEPTH+1 bytes with tx_en=0 -> TXRDY=0 after TX_DEPTH writes, tx_ovf=1; set tx_en -> TX_DEPTH frames are sent.
- With UART_LOOPBACK_EN defined, CTRL=0x71, IEN=1, write 0x5A -> TX pin stays 1, IRQ rises after one frame, RXDATA=0x5A.
